// File: rtl/mem_pkg.sv
// Shared definitions for the instruction-cache miss handler: FSM encoding,
// the NOP fill word, default counter width and the word-align helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_REQ  = 2'd2,
    ST_FILL = 2'd3
  } refill_state_t;

  localparam logic [31:0] NOP_WORD  = 32'd0;
  localparam int          CNT_W_DEF = 20;

  // MM is word addressed; byte offset bits of the fetch PC are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mm_refill_ctrl.sv
// Miss handler between the instruction cache and main memory. On a miss it
// requests the word from MM, then hands it to the cache as a one-cycle fill
// strobe. A stuck MM is abandoned after MM_TIMEOUT cycles and a NOP is filled.
module mm_refill_ctrl
  import mem_pkg::*;
#(
  parameter int MM_TIMEOUT = 64,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      PC,
  input  logic             HitWrite,
  input  logic             MM_Ack,
  input  logic [31:0]      MM_RData,
  output logic             MM_Req,
  output logic [31:0]      MM_Addr,
  output logic             Access_MM,
  output logic [31:0]      Data_MM,
  output logic             Busy,
  output logic             Timeout_Err,
  output logic [CNT_W-1:0] CNT_REFILL,
  output logic [CNT_W-1:0] CNT_STALL
);

  localparam int TMR_W = (MM_TIMEOUT > 2) ? $clog2(MM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MM_TIMEOUT - 1);

  refill_state_t state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             tmr_expired;

  assign tmr_expired = (timer == TMR_LAST);

  // Outputs decoded straight from the state register (Moore, glitch-free).
  assign MM_Req    = (state == ST_REQ);
  assign Access_MM = (state == ST_FILL);
  assign Busy      = (state == ST_REQ) || (state == ST_FILL);

  // State register; reset lands in BOOT to blank the unreset HitWrite.
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_BOOT;
    else       state <= state_nxt;
  end

  // Next-state logic; an ack beats a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: state_nxt = ST_IDLE;
      ST_IDLE: if (!HitWrite) state_nxt = ST_REQ;
      ST_REQ:  if (MM_Ack || tmr_expired) state_nxt = ST_FILL;
      ST_FILL: state_nxt = ST_IDLE;
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Datapath: address latch, fill data, saturating timer, sticky error, counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MM_Addr     <= 32'd0;
      Data_MM     <= 32'd0;
      timer       <= '0;
      Timeout_Err <= 1'b0;
      CNT_REFILL  <= '0;
      CNT_STALL   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!HitWrite) begin
            MM_Addr <= word_align(PC);
            timer   <= '0;
          end
        end
        ST_REQ: begin
          CNT_STALL <= CNT_STALL + CNT_W'(1);
          if (timer != '1) timer <= timer + TMR_W'(1);
          if (MM_Ack) begin
            Data_MM <= MM_RData;
          end else if (tmr_expired) begin
            Data_MM     <= NOP_WORD;
            Timeout_Err <= 1'b1;
          end
        end
        ST_FILL: CNT_REFILL <= CNT_REFILL + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_refill_ctrl.sv
// Directed bench for mm_refill_ctrl: reset, single miss, timeout, ack on the
// timeout cycle, reset mid-request and a back-to-back run against a small
// 8-entry FIFO cache model.
module tb_mm_refill_ctrl;

  localparam int CNT_W = 20;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [31:0]      PC;
  logic             HitWrite;
  logic             MM_Ack;
  logic [31:0]      MM_RData;
  logic             MM_Req;
  logic [31:0]      MM_Addr;
  logic             Access_MM;
  logic [31:0]      Data_MM;
  logic             Busy;
  logic             Timeout_Err;
  logic [CNT_W-1:0] CNT_REFILL;
  logic [CNT_W-1:0] CNT_STALL;

  int checks = 0;
  int errors = 0;

  mm_refill_ctrl #(.MM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .HitWrite(HitWrite),
    .MM_Ack(MM_Ack), .MM_RData(MM_RData), .MM_Req(MM_Req), .MM_Addr(MM_Addr),
    .Access_MM(Access_MM), .Data_MM(Data_MM), .Busy(Busy),
    .Timeout_Err(Timeout_Err), .CNT_REFILL(CNT_REFILL), .CNT_STALL(CNT_STALL)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; inputs are driven and outputs sampled on the negedge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reset, then pass BOOT into IDLE with the cache reporting a hit.
  task automatic do_reset();
    RESET = 1'b1; HitWrite = 1'b1; MM_Ack = 1'b0; MM_RData = 32'd0; PC = 32'd0;
    tick(); tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1; HitWrite = 1'bx; MM_Ack = 1'b0; MM_RData = 32'd0; PC = 32'h44;
    tick(); tick();
    checks++;
    if ({MM_Req, Access_MM, Busy, Timeout_Err} !== 4'b0 || MM_Addr !== 32'd0 ||
        Data_MM !== 32'd0 || CNT_REFILL !== '0 || CNT_STALL !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b acc=%b busy=%b err=%b addr=%h data=%h ref=%0d stall=%0d, expected all 0",
               MM_Req, Access_MM, Busy, Timeout_Err, MM_Addr, Data_MM, CNT_REFILL, CNT_STALL);
    end
    // Release with a miss showing: BOOT must blank it for one cycle.
    RESET = 1'b0; HitWrite = 1'b0;
    tick();
    checks++;
    if (MM_Req !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL boot_blank: req=%b busy=%b, expected 0 0", MM_Req, Busy);
    end
    tick();
    checks++;
    if (MM_Req !== 1'b1 || MM_Addr !== 32'h44) begin
      errors++;
      $display("FAIL idle_after_boot: req=%b addr=%h, expected 1 00000044", MM_Req, MM_Addr);
    end
  endtask

  task automatic test_single_miss();
    do_reset();
    PC = 32'h0000_0042; HitWrite = 1'b0;
    tick();
    checks++;
    if (MM_Req !== 1'b1 || MM_Addr !== 32'h40 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL miss_req: req=%b addr=%h busy=%b, expected 1 00000040 1", MM_Req, MM_Addr, Busy);
    end
    PC = 32'h0000_1000;  // ignored while in REQ
    tick();
    tick();
    MM_Ack = 1'b1; MM_RData = 32'h2002_0005;
    tick();
    MM_Ack = 1'b0; MM_RData = 32'h0; HitWrite = 1'b1;
    checks++;
    if (Access_MM !== 1'b1 || Data_MM !== 32'h2002_0005 || MM_Req !== 1'b0 ||
        CNT_STALL !== CNT_W'(3) || MM_Addr !== 32'h40) begin
      errors++;
      $display("FAIL miss_fill: acc=%b data=%h req=%b stall=%0d addr=%h, expected 1 20020005 0 3 00000040",
               Access_MM, Data_MM, MM_Req, CNT_STALL, MM_Addr);
    end
    tick();
    checks++;
    if (Access_MM !== 1'b0 || CNT_REFILL !== CNT_W'(1) || Busy !== 1'b0) begin
      errors++;
      $display("FAIL miss_done: acc=%b refill=%0d busy=%b, expected 0 1 0", Access_MM, CNT_REFILL, Busy);
    end
    tick();
    checks++;
    if (MM_Req !== 1'b0 || CNT_REFILL !== CNT_W'(1) || Timeout_Err !== 1'b0) begin
      errors++;
      $display("FAIL miss_no_retrigger: req=%b refill=%0d err=%b, expected 0 1 0", MM_Req, CNT_REFILL, Timeout_Err);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    // Continues from test_single_miss: stall=3, refill=1, Data_MM=20020005.
    PC = 32'h0000_0080; HitWrite = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (MM_Req === 1'b1) req_cycles++;
      if (Access_MM === 1'b1) break;
    end
    checks++;
    if (req_cycles != 4 || Access_MM !== 1'b1) begin
      errors++;
      $display("FAIL timeout_len: req_cycles=%0d acc=%b, expected 4 1", req_cycles, Access_MM);
    end
    HitWrite = 1'b1;
    checks++;
    if (Data_MM !== 32'd0 || Timeout_Err !== 1'b1 || CNT_STALL !== CNT_W'(7)) begin
      errors++;
      $display("FAIL timeout_fill: data=%h err=%b stall=%0d, expected 00000000 1 7", Data_MM, Timeout_Err, CNT_STALL);
    end
    tick();
    MM_Ack = 1'b1; MM_RData = 32'h1234_5678;  // late ack in IDLE
    tick();
    MM_Ack = 1'b0;
    tick();
    checks++;
    if (Access_MM !== 1'b0 || MM_Req !== 1'b0 || Data_MM !== 32'd0 ||
        CNT_REFILL !== CNT_W'(2) || Timeout_Err !== 1'b1) begin
      errors++;
      $display("FAIL late_ack: acc=%b req=%b data=%h refill=%0d err=%b, expected 0 0 00000000 2 1",
               Access_MM, MM_Req, Data_MM, CNT_REFILL, Timeout_Err);
    end
  endtask

  task automatic test_ack_on_timeout();
    do_reset();
    PC = 32'h0000_0100; HitWrite = 1'b0;
    tick(); tick(); tick(); tick();  // now in 4th REQ cycle
    MM_Ack = 1'b1; MM_RData = 32'hDEAD_BEEF;
    tick();
    MM_Ack = 1'b0; HitWrite = 1'b1;
    checks++;
    if (Access_MM !== 1'b1 || Data_MM !== 32'hDEAD_BEEF || Timeout_Err !== 1'b0 || CNT_STALL !== CNT_W'(4)) begin
      errors++;
      $display("FAIL ack_on_timeout: acc=%b data=%h err=%b stall=%0d, expected 1 deadbeef 0 4",
               Access_MM, Data_MM, Timeout_Err, CNT_STALL);
    end
    tick();
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    PC = 32'h0000_0200; HitWrite = 1'b0;
    tick(); tick();  // 2nd REQ cycle
    RESET = 1'b1;
    tick();
    checks++;
    if (MM_Req !== 1'b0 || Busy !== 1'b0 || CNT_STALL !== '0 || CNT_REFILL !== '0 || MM_Addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_req: req=%b busy=%b stall=%0d refill=%0d addr=%h, expected 0 0 0 0 00000000",
               MM_Req, Busy, CNT_STALL, CNT_REFILL, MM_Addr);
    end
    RESET = 1'b0; HitWrite = 1'b1; MM_Ack = 1'b1; MM_RData = 32'hCAFE_F00D;
    tick();
    MM_Ack = 1'b0;
    tick();
    checks++;
    if (Access_MM !== 1'b0 || MM_Req !== 1'b0 || Data_MM !== 32'd0 || CNT_REFILL !== '0) begin
      errors++;
      $display("FAIL ack_after_reset: acc=%b req=%b data=%h refill=%0d, expected 0 0 00000000 0",
               Access_MM, MM_Req, Data_MM, CNT_REFILL);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] fifo [8];
    logic        fvld [8];
    int          wr_ptr;
    int          misses;
    logic [31:0] addr;
    logic        hit;
    logic        seen;
    do_reset();
    wr_ptr = 0; misses = 0;
    for (int k = 0; k < 8; k++) begin fifo[k] = 32'd0; fvld[k] = 1'b0; end
    for (int n = 0; n < 10; n++) begin
      addr = (n < 9) ? 32'(n * 4) : 32'h0;
      hit = 1'b0;
      for (int k = 0; k < 8; k++) if (fvld[k] && fifo[k] == addr) hit = 1'b1;
      PC = addr;
      if (!hit) begin
        misses++;
        HitWrite = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
          tick();
          if (MM_Req === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || MM_Addr !== addr) begin
          errors++;
          $display("FAIL b2b_req[%0d]: seen=%b addr=%h, expected 1 %h", n, seen, MM_Addr, addr);
        end
        MM_Ack = 1'b1; MM_RData = addr ^ 32'hA5A5_0000;
        tick();
        MM_Ack = 1'b0; HitWrite = 1'b1;
        checks++;
        if (Access_MM !== 1'b1 || Data_MM !== (addr ^ 32'hA5A5_0000)) begin
          errors++;
          $display("FAIL b2b_fill[%0d]: acc=%b data=%h, expected 1 %h", n, Access_MM, Data_MM, addr ^ 32'hA5A5_0000);
        end
        fifo[wr_ptr] = addr; fvld[wr_ptr] = 1'b1;
        wr_ptr = (wr_ptr + 1) % 8;
      end
      tick();
    end
    tick();
    checks++;
    if (misses != 10 || CNT_REFILL !== CNT_W'(10) || Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: misses=%0d refill=%0d busy=%b, expected 10 10 0", misses, CNT_REFILL, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid_req();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
